onehot_event_encoder: RTL and testbench

ONEHOT_EVENT_ENCODER -- requirements
Module: onehot_event_encoder

---
 rtl/onehot_event_encoder.sv | 83 ++++++++
 tb/tb_onehot_event_encoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/onehot_event_encoder.sv
// Records one-hot event posts in a pending set and delivers them as binary
// indices, lowest line first, through a one-entry valid/ready output stage.
module onehot_event_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] code,
  output logic [7:0] pending,
  output logic       overflow
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [7:0] pending_q, pending_d;
  logic       overflow_q, overflow_d;

  logic       transfer_s;
  logic       load_s;
  logic [2:0] low_idx_s;
  logic [7:0] load_mask_s;

  function automatic logic [2:0] lowest_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = i[2:0];
      end
    end
    return idx;
  endfunction

  // Handshake, load decision and next-state computation.
  always_comb begin
    transfer_s  = (state_q == FULL) && out_ready;
    load_s      = ((state_q == EMPTY) || transfer_s) && (pending_q != 8'h00);
    low_idx_s   = lowest_index(pending_q);
    load_mask_s = load_s ? (8'h01 << low_idx_s) : 8'h00;

    pending_d  = (pending_q & ~load_mask_s) | req;
    // A re-post on the line being loaded this cycle is a fresh event, not an overflow.
    overflow_d = overflow_q | (|(req & pending_q & ~load_mask_s));

    if (load_s) begin
      state_d = FULL;
      code_d  = low_idx_s;
    end else if (transfer_s) begin
      state_d = EMPTY;
      code_d  = code_q;
    end else begin
      state_d = state_q;
      code_d  = code_q;
    end
  end

  // State registers; reset overrides any load, transfer or post.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      code_q     <= 3'd0;
      pending_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign code      = code_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_onehot_event_encoder.sv
// Directed self-checking bench for onehot_event_encoder.
module tb_onehot_event_encoder;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] code;
  logic [7:0] pending;
  logic       overflow;

  int total;
  int bad;

  onehot_event_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .code      (code),
    .pending   (pending),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [2:0] c,
                         input logic [7:0] p, input logic o);
    chk({tag, ".valid"},   {7'd0, out_valid}, {7'd0, v});
    chk({tag, ".code"},    {5'd0, code},      {5'd0, c});
    chk({tag, ".pending"}, pending,           p);
    chk({tag, ".ovf"},     {7'd0, overflow},  {7'd0, o});
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    req = 8'h00;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    chk_all("reset", 1'b0, 3'd0, 8'h00, 1'b0);

    // Single event on line 5
    out_ready = 1'b1;
    req = 8'h20;
    tick();
    req = 8'h00;
    chk_all("single.post", 1'b0, 3'd0, 8'h20, 1'b0);
    tick();
    chk_all("single.out", 1'b1, 3'd5, 8'h00, 1'b0);
    tick();
    chk_all("single.empty", 1'b0, 3'd5, 8'h00, 1'b0);

    // Burst on lines 0 and 7
    req = 8'h81;
    tick();
    req = 8'h00;
    chk_all("burst.post", 1'b0, 3'd5, 8'h81, 1'b0);
    tick();
    chk_all("burst.first", 1'b1, 3'd0, 8'h80, 1'b0);
    tick();
    chk_all("burst.second", 1'b1, 3'd7, 8'h00, 1'b0);
    tick();
    chk_all("burst.empty", 1'b0, 3'd7, 8'h00, 1'b0);

    // Stall with lines 1 and 2
    out_ready = 1'b0;
    req = 8'h06;
    tick();
    req = 8'h00;
    chk_all("stall.post", 1'b0, 3'd7, 8'h06, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("stall.hold", 1'b1, 3'd1, 8'h04, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    chk_all("stall.second", 1'b1, 3'd2, 8'h00, 1'b0);
    tick();
    chk_all("stall.empty", 1'b0, 3'd2, 8'h00, 1'b0);

    // Overflow: line 1 re-posted while pending and the stage is full
    out_ready = 1'b0;
    req = 8'h01;
    tick();
    req = 8'h00;
    tick();
    chk_all("ovf.full", 1'b1, 3'd0, 8'h00, 1'b0);
    req = 8'h02;
    tick();
    chk_all("ovf.pend1", 1'b1, 3'd0, 8'h02, 1'b0);
    req = 8'h03;
    tick();
    req = 8'h00;
    chk_all("ovf.set", 1'b1, 3'd0, 8'h03, 1'b1);
    out_ready = 1'b1;
    tick();
    chk_all("ovf.drain0", 1'b1, 3'd0, 8'h02, 1'b1);
    tick();
    chk_all("ovf.drain1", 1'b1, 3'd1, 8'h00, 1'b1);
    tick();
    chk_all("ovf.sticky", 1'b0, 3'd1, 8'h00, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all("ovf.reset", 1'b0, 3'd0, 8'h00, 1'b0);

    // Re-post of line 0 in the cycle it loads
    req = 8'h01;
    tick();
    chk_all("repost.post", 1'b0, 3'd0, 8'h01, 1'b0);
    tick();
    req = 8'h00;
    chk_all("repost.load", 1'b1, 3'd0, 8'h01, 1'b0);
    tick();
    chk_all("repost.second", 1'b1, 3'd0, 8'h00, 1'b0);
    tick();
    chk_all("repost.empty", 1'b0, 3'd0, 8'h00, 1'b0);

    // Reset in the middle of operation
    out_ready = 1'b0;
    req = 8'hF0;
    tick();
    req = 8'h10;
    tick();
    req = 8'h00;
    chk_all("midrst.pre", 1'b1, 3'd4, 8'hF0, 1'b0);
    reset = 1'b1;
    req = 8'h0F;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    req = 8'h00;
    chk_all("midrst.rst", 1'b0, 3'd0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("midrst.idle", 1'b0, 3'd0, 8'h00, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
